vend_dispense_ctrl: RTL and testbench

//  Sequences physical dispensing for the coin-credit vending FSM. Buffers vend events
//  (product + change code) in a small queue. Drives one product motor and one shared
//  5rs coin hopper through request/acknowledge handshakes, with timeout fault detection.

---
 rtl/vend_pkg.sv | 43 ++++
 rtl/vend_evt_fifo.sv | 64 ++++++
 rtl/vend_dispense_ctrl.sv | 136 +++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vend dispense controller: change codes, FSM state encoding
// and the 3-bit queued event record {vend, change}.
package vend_pkg;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_VEND     = 3'd1;
  localparam logic [2:0] ST_CHANGE   = 3'd2;
  localparam logic [2:0] ST_CHG_WAIT = 3'd3;
  localparam logic [2:0] ST_FAULT    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE     = ST_IDLE,
    S_VEND     = ST_VEND,
    S_CHANGE   = ST_CHANGE,
    S_CHG_WAIT = ST_CHG_WAIT,
    S_FAULT    = ST_FAULT
  } state_e;

  localparam int EVT_W = 3;

  typedef struct packed {
    logic       vend;
    logic [1:0] chg;
  } evt_t;

  // The illegal code 2'b11 behaves exactly like "no change".
  function automatic logic [1:0] norm_chg(input logic [1:0] c);
    return (c == 2'b11) ? CHG_NONE : c;
  endfunction

  function automatic logic [1:0] chg_coins(input logic [1:0] c);
    case (c)
      CHG_5:   return 2'd1;
      CHG_10:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_evt_fifo.sv
// Small event queue: DEPTH x W entries, read/write pointers plus an exact
// occupancy count. Push is ignored when full, pop is ignored when empty.
module vend_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic [W-1:0]                   din_i,
  input  logic                           pop_i,
  output logic [W-1:0]                   dout_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + PW'(1);
    if (do_pop)  rd_d = rd_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: pops queued vend events and runs the product motor and the
// 5rs coin hopper through their handshakes, latching a sticky fault on timeout.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int QDEPTH         = 4,
  parameter int MOTOR_TIMEOUT  = 32,
  parameter int HOPPER_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic                          ev_vend,
  input  logic [1:0]                    ev_change,
  output logic                          motor_on,
  input  logic                          motor_done,
  output logic                          coin_eject,
  input  logic                          coin_ack,
  output logic                          busy,
  output logic                          fault,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count
);

  localparam int MAX_TO = (MOTOR_TIMEOUT > HOPPER_TIMEOUT) ? MOTOR_TIMEOUT : HOPPER_TIMEOUT;
  localparam int TMR_W  = (MAX_TO > 1) ? $clog2(MAX_TO) : 1;

  state_e             state_q;
  logic               motor_on_q, coin_eject_q, fault_q;
  logic [TMR_W-1:0]   timer_q;
  logic [1:0]         coins_left_q;

  evt_t               in_evt, head_evt;
  logic [EVT_W-1:0]   head_raw;
  logic               store, pop, f_full, f_empty;

  // Events that would do nothing are acknowledged upstream but never queued.
  assign in_evt   = {ev_vend, norm_chg(ev_change)};
  assign store    = ev_valid && ev_ready && (in_evt.vend || (in_evt.chg != CHG_NONE));
  assign pop      = (state_q == S_IDLE) && !f_empty;
  assign head_evt = evt_t'(head_raw);

  vend_evt_fifo #(
    .DEPTH (QDEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (store),
    .din_i   (in_evt),
    .pop_i   (pop),
    .dout_o  (head_raw),
    .full_o  (f_full),
    .empty_o (f_empty),
    .count_o (q_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      motor_on_q   <= 1'b0;
      coin_eject_q <= 1'b0;
      fault_q      <= 1'b0;
      timer_q      <= '0;
      coins_left_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!f_empty) begin
            coins_left_q <= chg_coins(head_evt.chg);
            timer_q      <= '0;
            if (head_evt.vend) begin
              state_q    <= S_VEND;
              motor_on_q <= 1'b1;
            end else begin
              state_q      <= S_CHANGE;
              coin_eject_q <= 1'b1;
            end
          end
        end
        S_VEND: begin
          if (motor_done) begin
            motor_on_q <= 1'b0;
            if (coins_left_q != 2'd0) begin
              state_q      <= S_CHANGE;
              coin_eject_q <= 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end else if (timer_q == TMR_W'(MOTOR_TIMEOUT - 1)) begin
            state_q    <= S_FAULT;
            motor_on_q <= 1'b0;
            fault_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_CHANGE: begin
          coin_eject_q <= 1'b0;
          timer_q      <= '0;
          state_q      <= S_CHG_WAIT;
        end
        // An ack arriving during the eject cycle itself lands in CHANGE and is dropped.
        S_CHG_WAIT: begin
          if (coin_ack) begin
            coins_left_q <= coins_left_q - 2'd1;
            if (coins_left_q == 2'd1) begin
              state_q <= S_IDLE;
            end else begin
              state_q      <= S_CHANGE;
              coin_eject_q <= 1'b1;
            end
          end else if (timer_q == TMR_W'(HOPPER_TIMEOUT - 1)) begin
            state_q <= S_FAULT;
            fault_q <= 1'b1;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_FAULT: begin
          motor_on_q   <= 1'b0;
          coin_eject_q <= 1'b0;
          fault_q      <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign motor_on   = motor_on_q;
  assign coin_eject = coin_eject_q;
  assign fault      = fault_q;
  assign ev_ready   = !f_full && !fault_q;
  assign busy       = (state_q != S_IDLE) || !f_empty;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: a queue of expected motor/eject actions is filled as
// events are accepted and drained as the DUT performs them; scenario tasks check the rest.
module tb_vend_dispense_ctrl;

  localparam int QDEPTH = 4;
  localparam int MT     = 32;
  localparam int HT     = 16;
  localparam logic [1:0] ACT_V = 2'd1;
  localparam logic [1:0] ACT_C = 2'd2;

  logic       clk, rst, ev_valid, ev_ready, ev_vend;
  logic [1:0] ev_change;
  logic       motor_on, motor_done, coin_eject, coin_ack, busy, fault;
  logic [2:0] q_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [1:0] exp_q[$];

  logic motor_prev = 1'b0;
  bit   auto_motor = 1'b0;
  bit   ack_pend = 1'b0;
  int   mot_lat = 3;
  int   mot_cnt = 0;
  int   coin_budget = 1000;
  int   acks_given = 0;
  int   ejects_seen = 0;
  int   vends_seen = 0;
  int   last_ej_cyc = 0;

  vend_dispense_ctrl #(
    .QDEPTH         (QDEPTH),
    .MOTOR_TIMEOUT  (MT),
    .HOPPER_TIMEOUT (HT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_vend    (ev_vend),
    .ev_change  (ev_change),
    .motor_on   (motor_on),
    .motor_done (motor_done),
    .coin_eject (coin_eject),
    .coin_ack   (coin_ack),
    .busy       (busy),
    .fault      (fault),
    .q_count    (q_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // One clock: wait to the falling edge, score any action the DUT began, then drive the motor/hopper model.
  task automatic tick();
    logic [1:0] e;
    @(negedge clk);
    cyc++;
    if (motor_on === 1'b1 && motor_prev !== 1'b1) begin
      vends_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_vend: motor_on rose at cycle %0d, required no action", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e !== ACT_V) begin
          errors++;
          $display("FAIL sb_order: got vend at cycle %0d, required action %0d", cyc, e);
        end
      end
    end
    if (coin_eject === 1'b1) begin
      ejects_seen++;
      last_ej_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_eject: coin_eject at cycle %0d, required no action", cyc);
      end else begin
        e = exp_q.pop_front();
        if (e !== ACT_C) begin
          errors++;
          $display("FAIL sb_order: got eject at cycle %0d, required action %0d", cyc, e);
        end
      end
    end
    motor_prev = motor_on;
    motor_done = 1'b0;
    coin_ack   = 1'b0;
    if (ack_pend) begin
      ack_pend = 1'b0;
      if (coin_budget > 0) begin
        coin_budget--;
        coin_ack = 1'b1;
        acks_given++;
      end
    end
    if (coin_eject === 1'b1) ack_pend = 1'b1;
    if (auto_motor && motor_on === 1'b1) begin
      mot_cnt++;
      if (mot_cnt >= mot_lat) begin
        motor_done = 1'b1;
        mot_cnt = 0;
      end
    end else begin
      mot_cnt = 0;
    end
  endtask

  task automatic send(input logic v, input logic [1:0] c);
    int n = 0;
    int coins;
    ev_valid  = 1'b1;
    ev_vend   = v;
    ev_change = c;
    while (ev_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ev_ready=%b, required 1", ev_ready);
    end else begin
      coins = (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : 0;
      if (v) exp_q.push_back(ACT_V);
      repeat (coins) exp_q.push_back(ACT_C);
    end
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, busy, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d actions still pending, required 0", tag, exp_q.size());
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    ev_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    ack_pend = 1'b0;
    mot_cnt = 0;
    auto_motor = 1'b0;
    coin_budget = 1000;
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({motor_on, coin_eject, busy, fault} !== 4'b0000) begin
      errors++;
      $display("FAIL %s_outs: motor/eject/busy/fault=%b%b%b%b, required 0000", tag, motor_on, coin_eject, busy, fault);
    end
    checks++;
    if (q_count !== 3'd0) begin
      errors++;
      $display("FAIL %s_qcount: q_count=%0d, required 0", tag, q_count);
    end
    checks++;
    if (ev_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready: ev_ready=%b, required 1", tag, ev_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_reset_outputs("reset");
  endtask

  task automatic test_single();
    int e0, a0;
    auto_motor = 1'b1;
    mot_lat = 3;
    e0 = ejects_seen;
    a0 = acks_given;
    send(1'b1, 2'b10);
    checks++;
    if (q_count !== 3'd1 || motor_on !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: q_count=%0d motor_on=%b, required 1 and 0", q_count, motor_on);
    end
    tick();
    checks++;
    if (motor_on !== 1'b1) begin
      errors++;
      $display("FAIL single_latency: motor_on=%b after E1, required 1", motor_on);
    end
    wait_idle("single");
    checks++;
    if (ejects_seen - e0 != 2 || acks_given - a0 != 2) begin
      errors++;
      $display("FAIL single_coins: ejects=%0d acks=%0d, required 2 and 2", ejects_seen - e0, acks_given - a0);
    end
  endtask

  task automatic test_back_to_back();
    auto_motor = 1'b0;
    send(1'b1, 2'b00);
    send(1'b1, 2'b01);
    send(1'b0, 2'b10);
    send(1'b1, 2'b10);
    send(1'b1, 2'b00);
    checks++;
    if (q_count !== 3'd4 || ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: q_count=%0d ev_ready=%b, required 4 and 0", q_count, ev_ready);
    end
    ev_valid  = 1'b1;
    ev_vend   = 1'b1;
    ev_change = 2'b01;
    repeat (3) tick();
    ev_valid = 1'b0;
    checks++;
    if (q_count !== 3'd4) begin
      errors++;
      $display("FAIL b2b_nobypass: q_count=%0d, required 4", q_count);
    end
    auto_motor = 1'b1;
    wait_idle("b2b");
  endtask

  task automatic test_no_store();
    int v0, e0;
    auto_motor = 1'b1;
    v0 = vends_seen;
    e0 = ejects_seen;
    send(1'b0, 2'b00);
    checks++;
    if (q_count !== 3'd0) begin
      errors++;
      $display("FAIL nostore_00: q_count=%0d, required 0", q_count);
    end
    send(1'b0, 2'b11);
    checks++;
    if (q_count !== 3'd0) begin
      errors++;
      $display("FAIL nostore_11: q_count=%0d, required 0", q_count);
    end
    repeat (5) tick();
    checks++;
    if (vends_seen != v0 || ejects_seen != e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL nostore_quiet: vends=%0d ejects=%0d busy=%b, required 0 0 0", vends_seen - v0, ejects_seen - e0, busy);
    end
    send(1'b1, 2'b11);
    checks++;
    if (q_count !== 3'd1) begin
      errors++;
      $display("FAIL illegal_store: q_count=%0d, required 1", q_count);
    end
    wait_idle("illegal");
    checks++;
    if (vends_seen - v0 != 1 || ejects_seen != e0) begin
      errors++;
      $display("FAIL illegal_acts: vends=%0d ejects=%0d, required 1 and 0", vends_seen - v0, ejects_seen - e0);
    end
  endtask

  task automatic test_motor_timeout();
    int n = 0;
    auto_motor = 1'b0;
    send(1'b1, 2'b00);
    tick();
    checks++;
    if (motor_on !== 1'b1) begin
      errors++;
      $display("FAIL mto_start: motor_on=%b, required 1", motor_on);
    end
    while (fault !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n != MT) begin
      errors++;
      $display("FAIL mto_cycles: fault after %0d cycles, required %0d", n, MT);
    end
    checks++;
    if ({motor_on, coin_eject, ev_ready} !== 3'b000) begin
      errors++;
      $display("FAIL mto_outs: motor/eject/ready=%b%b%b, required 000", motor_on, coin_eject, ev_ready);
    end
    ev_valid  = 1'b1;
    ev_vend   = 1'b1;
    ev_change = 2'b00;
    repeat (3) tick();
    ev_valid = 1'b0;
    checks++;
    if (q_count !== 3'd0 || fault !== 1'b1 || motor_on !== 1'b0) begin
      errors++;
      $display("FAIL mto_frozen: q_count=%0d fault=%b motor_on=%b, required 0 1 0", q_count, fault, motor_on);
    end
    apply_reset();
  endtask

  task automatic test_hopper_timeout();
    int n = 0;
    int a0, e0;
    auto_motor  = 1'b1;
    coin_budget = 1;
    a0 = acks_given;
    e0 = ejects_seen;
    send(1'b1, 2'b10);
    while (fault !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (fault !== 1'b1) begin
      errors++;
      $display("FAIL hto_fault: fault=%b, required 1", fault);
    end
    checks++;
    if (cyc - last_ej_cyc != HT + 1) begin
      errors++;
      $display("FAIL hto_cycles: fault %0d cycles after eject, required %0d", cyc - last_ej_cyc, HT + 1);
    end
    checks++;
    if (acks_given - a0 != 1 || ejects_seen - e0 != 2 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL hto_coins: acks=%0d ejects=%0d pending=%0d, required 1 2 0", acks_given - a0, ejects_seen - e0, exp_q.size());
    end
    checks++;
    if ({motor_on, coin_eject, ev_ready} !== 3'b000) begin
      errors++;
      $display("FAIL hto_outs: motor/eject/ready=%b%b%b, required 000", motor_on, coin_eject, ev_ready);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid();
    int e0, v0;
    auto_motor  = 1'b1;
    coin_budget = 0;
    e0 = ejects_seen;
    send(1'b0, 2'b10);
    send(1'b1, 2'b00);
    send(1'b1, 2'b00);
    checks++;
    if (q_count !== 3'd2 || ejects_seen - e0 != 1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: q_count=%0d ejects=%0d busy=%b, required 2 1 1", q_count, ejects_seen - e0, busy);
    end
    rst = 1'b1;
    tick();
    check_reset_outputs("midrst");
    rst = 1'b0;
    exp_q.delete();
    ack_pend = 1'b0;
    coin_budget = 1000;
    v0 = vends_seen;
    e0 = ejects_seen;
    repeat (4) tick();
    checks++;
    if (vends_seen != v0 || ejects_seen != e0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midrst_quiet: vends=%0d ejects=%0d busy=%b, required 0 0 0", vends_seen - v0, ejects_seen - e0, busy);
    end
  endtask

  task automatic test_after_reset();
    auto_motor  = 1'b1;
    coin_budget = 1000;
    send(1'b1, 2'b01);
    send(1'b0, 2'b01);
    wait_idle("post");
  endtask

  initial begin
    rst        = 1'b1;
    ev_valid   = 1'b0;
    ev_vend    = 1'b0;
    ev_change  = 2'b00;
    motor_done = 1'b0;
    coin_ack   = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_no_store();
    test_motor_timeout();
    test_hopper_timeout();
    test_reset_mid();
    test_after_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
